fifo_ctl_1c_sf: RTL
===================

Name: fifo_ctl_1c_sf

Overview:
- Single-clock synchronous FIFO controller that drives a flip-flop RAM with one asynchronous read port and one synchronous write port. It sits directly upstream of that RAM.
- It converts active-low push/pop requests into RAM write-enable/chip-select and write/read addresses, and keeps occupancy state.
- It generates status flags: empty, almost-empty, half-full, almost-full, full, plus a sticky error.
- The RAM's data_out is the FIFO head word whenever empty is low.

Parameters:
- DEPTH, 16, number of words; 2-256, any value (not restricted to a power of 2).
- AE_LEVEL, 2, almost_empty asserted when word_count <= AE_LEVEL; range 1..DEPTH-1.
- AF_LEVEL, 2, almost_full asserted when word_count >= DEPTH-AF_LEVEL; range 1..DEPTH-1.
- ADDR_WIDTH, $clog2(DEPTH), RAM address width; do not override.
- COUNT_WIDTH, $clog2(DEPTH+1), word_count width; do not override.

Ports:
- clock  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- push_n  input  1  push request, active low.
- pop_n  input  1  pop request, active low.
- ram_cs_n  output  1  RAM chip select, active low; low exactly when ram_we_n is low.
- ram_we_n  output  1  RAM write enable, active low.
- wr_addr  output  ADDR_WIDTH  RAM write address.
- rd_addr  output  ADDR_WIDTH  RAM read address (head of FIFO).
- word_count  output  COUNT_WIDTH  current occupancy, 0..DEPTH.
- empty  output  1  word_count == 0.
- almost_empty  output  1  word_count <= AE_LEVEL.
- half_full  output  1  word_count >= (DEPTH+1)/2.
- almost_full  output  1  word_count >= DEPTH-AF_LEVEL.
- full  output  1  word_count == DEPTH.
- error  output  1  sticky overflow/underflow indicator.

Behaviour:
- Reset (asynchronous, effective immediately):
  - wr_addr = 0, rd_addr = 0, word_count = 0, error = 0.
  - Therefore empty = 1, almost_empty = 1, half_full = 0, almost_full = 0, full = 0.
  - ram_we_n = 1, ram_cs_n = 1.
  - Reset mid-operation discards all contents; RAM contents are don't-care afterwards.
- Accept rules, evaluated combinationally each cycle:
  - push_ok = ~push_n & (~full | ~pop_n).
  - pop_ok = ~pop_n & ~empty.
- RAM write control:
  - ram_we_n = ram_cs_n = ~push_ok (combinational).
  - The RAM captures data at wr_addr on the same rising edge, so write latency is 1 cycle.
- Read path:
  - rd_addr is registered.
  - Head data is valid from the RAM asynchronously whenever empty = 0.
  - Pop consumes the head at the rising edge; the next word appears after rd_addr updates.
  - A word pushed at edge N is poppable in the cycle after edge N (empty falls after edge N).
- Pointers:
  - On push_ok: wr_addr <= (wr_addr == DEPTH-1) ? 0 : wr_addr+1.
  - On pop_ok: rd_addr advances with the same wrap rule.
  - Wrap is explicit; do not rely on modulo-2^ADDR_WIDTH.
- Count update (registered; all flags are pure decodes of the registered word_count and are glitch-free from flops):
  - push_ok & ~pop_ok: +1.
  - pop_ok & ~push_ok: -1.
  - both or neither: unchanged.
- Simultaneous push + pop:
  - When full: both accepted, count stays DEPTH. The write lands on the slot being read this cycle; this is safe because the read is asynchronous and completes before the edge.
  - When empty: push accepted; pop rejected as underflow; error set; count becomes 1.
  - Otherwise: both accepted, count unchanged.
- Error:
  - Set on overflow (~push_n & full & pop_n) or underflow (~pop_n & empty).
  - Rejected requests change no state other than error.
  - Error stays set until reset.
- Overflow does not assert ram_we_n low, so RAM contents are protected.

Optional Feature:
- Macro: KW_FIFO_CTL_HWM_EN.
- Defined:
  - Adds output port peak_count [COUNT_WIDTH-1:0] and input port hwm_clear (1-bit, active high).
  - peak_count is registered, reset to 0, and updates to max(peak_count, next word_count) each cycle.
  - hwm_clear loads peak_count with the next word_count (clear has priority over max).
- Undefined: neither port exists, no extra flops; all other behaviour is identical.

Test Plan:
- Reset then idle, DEPTH=16 -> empty=1, almost_empty=1, full=0, word_count=0, error=0, rd_addr=wr_addr=0, ram_we_n=1.
- 16 consecutive pushes, DEPTH=16, AF_LEVEL=2 -> almost_full rises after push 14, full after push 16, half_full after push 8. A 17th push with pop_n=1 -> error=1, ram_we_n stays 1, wr_addr=0, count 16.
- DEPTH=5: 7 pushes interleaved with 7 pops -> pointers wrap 4->0 and never reach 5 or higher; head data order matches push order (values 0xA0..0xA6).
- Full FIFO with push_n=0 and pop_n=0 for 3 cycles -> count stays 5, error stays 0, ram_we_n=0 each cycle, rd_addr and wr_addr both advance by 3 mod 5.
- Empty FIFO with push_n=0 and pop_n=0 -> error=1, word_count=1, wr_addr=1, rd_addr=0, empty falls next cycle.
- Assert reset mid-stream at count 7, asynchronously between edges -> all outputs return to reset values before the next edge. With KW_FIFO_CTL_HWM_EN: peak_count=0 after reset; after 9 pushes and 4 pops, peak_count=9; hwm_clear -> peak_count=5.

Source files
------------

// File: rtl/fifo_ctl_1c_sf_if.sv
// Handshake and status bundle between a FIFO client and fifo_ctl_1c_sf.
// Widths follow DEPTH exactly as the controller derives them.
interface fifo_ctl_1c_sf_if #(
    parameter int unsigned DEPTH = 16
);
    localparam int unsigned ADDR_WIDTH  = $clog2(DEPTH);
    localparam int unsigned COUNT_WIDTH = $clog2(DEPTH + 1);

    logic                   push_n;
    logic                   pop_n;
    logic                   ram_cs_n;
    logic                   ram_we_n;
    logic [ADDR_WIDTH-1:0]  wr_addr;
    logic [ADDR_WIDTH-1:0]  rd_addr;
    logic [COUNT_WIDTH-1:0] word_count;
    logic                   empty;
    logic                   almost_empty;
    logic                   half_full;
    logic                   almost_full;
    logic                   full;
    logic                   error;

    modport master (
        output push_n, pop_n,
        input  ram_cs_n, ram_we_n, wr_addr, rd_addr, word_count,
        input  empty, almost_empty, half_full, almost_full, full, error
    );

    modport slave (
        input  push_n, pop_n,
        output ram_cs_n, ram_we_n, wr_addr, rd_addr, word_count,
        output empty, almost_empty, half_full, almost_full, full, error
    );
endinterface

// File: rtl/fifo_ctl_1c_sf.sv
// Single-clock FIFO controller for a flop RAM (async read, sync write).
// Optional high-water mark tracking enabled by macro KW_FIFO_CTL_HWM_EN.
module fifo_ctl_1c_sf #(
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned AE_LEVEL    = 2,
    parameter int unsigned AF_LEVEL    = 2,
    parameter int unsigned ADDR_WIDTH  = $clog2(DEPTH),
    parameter int unsigned COUNT_WIDTH = $clog2(DEPTH + 1)
) (
    input  logic                   clock,
    input  logic                   reset,
`ifdef KW_FIFO_CTL_HWM_EN
    input  logic                   hwm_clear,
    output logic [COUNT_WIDTH-1:0] peak_count,
`endif
    fifo_ctl_1c_sf_if.slave        bus
);
    localparam logic [ADDR_WIDTH-1:0]  LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [COUNT_WIDTH-1:0] AE_CNT    = COUNT_WIDTH'(AE_LEVEL);
    localparam logic [COUNT_WIDTH-1:0] HF_CNT    = COUNT_WIDTH'((DEPTH + 1) / 2);
    localparam logic [COUNT_WIDTH-1:0] AF_CNT    = COUNT_WIDTH'(DEPTH - AF_LEVEL);
    localparam logic [COUNT_WIDTH-1:0] FULL_CNT  = COUNT_WIDTH'(DEPTH);

    logic                   push_ok;
    logic                   pop_ok;
    logic [ADDR_WIDTH-1:0]  wr_addr_q, wr_addr_d;
    logic [ADDR_WIDTH-1:0]  rd_addr_q, rd_addr_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic                   empty_q, almost_empty_q, half_full_q, almost_full_q, full_q;
    logic                   error_q, error_d;

    // Accept decisions, pointer wrap and next occupancy.
    always_comb begin
        push_ok   = ~bus.push_n & (~full_q | ~bus.pop_n);
        pop_ok    = ~bus.pop_n & ~empty_q;
        wr_addr_d = wr_addr_q;
        rd_addr_d = rd_addr_q;
        count_d   = count_q;
        error_d   = error_q | (~bus.push_n & full_q & bus.pop_n) | (~bus.pop_n & empty_q);

        if (push_ok) begin
            wr_addr_d = (wr_addr_q == LAST_ADDR) ? '0 : wr_addr_q + ADDR_WIDTH'(1);
        end
        if (pop_ok) begin
            rd_addr_d = (rd_addr_q == LAST_ADDR) ? '0 : rd_addr_q + ADDR_WIDTH'(1);
        end
        if (push_ok && !pop_ok) begin
            count_d = count_q + COUNT_WIDTH'(1);
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - COUNT_WIDTH'(1);
        end
    end

    // Flags are flopped decodes of the next count so they never glitch.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_addr_q      <= '0;
            rd_addr_q      <= '0;
            count_q        <= '0;
            empty_q        <= 1'b1;
            almost_empty_q <= 1'b1;
            half_full_q    <= 1'b0;
            almost_full_q  <= 1'b0;
            full_q         <= 1'b0;
            error_q        <= 1'b0;
        end else begin
            wr_addr_q      <= wr_addr_d;
            rd_addr_q      <= rd_addr_d;
            count_q        <= count_d;
            empty_q        <= (count_d == '0);
            almost_empty_q <= (count_d <= AE_CNT);
            half_full_q    <= (count_d >= HF_CNT);
            almost_full_q  <= (count_d >= AF_CNT);
            full_q         <= (count_d == FULL_CNT);
            error_q        <= error_d;
        end
    end

`ifdef KW_FIFO_CTL_HWM_EN
    logic [COUNT_WIDTH-1:0] peak_q, peak_d;

    // Clear reloads from the next occupancy rather than zero.
    always_comb begin
        peak_d = peak_q;
        if (hwm_clear) begin
            peak_d = count_d;
        end else if (count_d > peak_q) begin
            peak_d = count_d;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            peak_q <= '0;
        end else begin
            peak_q <= peak_d;
        end
    end

    assign peak_count = peak_q;
`endif

    // RAM write strobe is combinational so the write lands on this edge.
    assign bus.ram_we_n     = ~push_ok;
    assign bus.ram_cs_n     = ~push_ok;
    assign bus.wr_addr      = wr_addr_q;
    assign bus.rd_addr      = rd_addr_q;
    assign bus.word_count   = count_q;
    assign bus.empty        = empty_q;
    assign bus.almost_empty = almost_empty_q;
    assign bus.half_full    = half_full_q;
    assign bus.almost_full  = almost_full_q;
    assign bus.full         = full_q;
    assign bus.error        = error_q;
endmodule
